// File: rtl/game_pkg.sv
// game_pkg: shared game-flow types and constants.
//   game_state_t : 3-bit game-flow state used by level_sequencer and exported on its state port.
//   BDR..CK2     : tile codes shared by the level modules and the renderer.
//   max_u        : elaboration-time maximum helper.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        PLAY     = 3'd2,
        WIN      = 3'd3,
        LOSE     = 3'd4,
        DONE     = 3'd5,
        GAMEOVER = 3'd6
    } game_state_t;

    localparam logic [2:0] BDR = 3'd0;
    localparam logic [2:0] SKY = 3'd1;
    localparam logic [2:0] BLK = 3'd2;
    localparam logic [2:0] GND = 3'd3;
    localparam logic [2:0] TKN = 3'd4;
    localparam logic [2:0] CK1 = 3'd5;
    localparam logic [2:0] CK2 = 3'd6;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/second_ticker.sv
// second_ticker: one-second tick generator for level_sequencer.
//   vga_clock : clock.
//   reset     : synchronous, active-high.
//   clear     : restarts the divider; the next tick comes CLOCK_HZ cycles later.
//   tick      : single-cycle pulse every CLOCK_HZ cycles.
module second_ticker #(
    parameter int unsigned CLOCK_HZ = 25_000_000
) (
    input  logic vga_clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (CLOCK_HZ > 1) ? $clog2(CLOCK_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLOCK_HZ - 1);

    logic [CW-1:0] count_q, count_d;

    // A tick coinciding with clear is kept: it is usually what caused the clear.
    assign tick = (count_q == LAST);

    always_comb begin
        count_d = count_q + 1'b1;
        if (tick)  count_d = '0;
        if (clear) count_d = '0;
    end

    always_ff @(posedge vga_clock) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

endmodule

// File: rtl/level_sequencer.sv
// level_sequencer: game-flow controller selecting the active level, resetting it on entry,
// running the per-level countdown and tracking lives and the final outcome.
//   vga_clock, reset      : clock; synchronous active-high reset.
//   jump_button           : debounced start/continue button, rising edge acts.
//   level_win, level_lose : flags from the selected level, honoured only in PLAY.
//   level_sel             : level index for the mux (0 = attract screen).
//   level_reset           : active-low reset to the level modules, low throughout LOAD.
//   seconds               : seconds remaining in the current level.
//   state                 : current game_state_t.
//   game_won, game_lost   : high in DONE / GAMEOVER.
//   leds                  : {game_lost, game_won, lives[3:0], level_sel[3:0]}.
// Build option: define LEVEL_TIMER_EN to enable the countdown and timeout-to-LOSE; otherwise
// seconds stays at TIME_LIMIT and only WIN/LOSE hold timing uses the ticker.
module level_sequencer
    import game_pkg::*;
#(
    parameter int unsigned CLOCK_HZ     = 25_000_000,
    parameter int unsigned NUM_LEVELS   = 3,
    parameter int unsigned TIME_LIMIT   = 60,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned LOAD_CYCLES  = 4,
    parameter int unsigned HOLD_SECONDS = 2
) (
    input  logic       vga_clock,
    input  logic       reset,
    input  logic       jump_button,
    input  logic       level_win,
    input  logic       level_lose,
    output logic [3:0] level_sel,
    output logic       level_reset,
    output int         seconds,
    output logic [2:0] state,
    output logic       game_won,
    output logic       game_lost,
    output logic [9:0] leds
);

    // One counter serves both LOAD cycles and WIN/LOSE hold ticks.
    localparam int unsigned   HOLD_MAX   = max_u(LOAD_CYCLES, HOLD_SECONDS);
    localparam int unsigned   HW         = $clog2(HOLD_MAX + 1);
    localparam logic [HW-1:0] LOAD_LAST  = HW'(LOAD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_SECONDS - 1);
    localparam logic [3:0]    LAST_LEVEL = 4'(NUM_LEVELS - 1);
    localparam logic [3:0]    LIVES_INIT = 4'(LIVES);
    localparam int            SECS_INIT  = int'(TIME_LIMIT);

    game_state_t   state_q, state_d;
    logic [3:0]    sel_q, sel_d, lives_q, lives_d;
    logic          lrst_q, lrst_d, won_q, won_d, lost_q, lost_d;
    logic          jump_prev_q;
    int            secs_q, secs_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          tick, clear, jump_rise, lose_entry;

    assign jump_rise = jump_button & ~jump_prev_q;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        lives_d    = lives_q;
        won_d      = won_q;
        lost_d     = lost_q;
        secs_d     = secs_q;
        hold_d     = hold_q;
        lose_entry = 1'b0;

        unique case (state_q)
            IDLE: begin
                sel_d = 4'd0;
                if (jump_rise) begin
                    state_d = LOAD;
                    sel_d   = 4'd1;
                end
            end
            LOAD: begin
                if (hold_q == LOAD_LAST) state_d = PLAY;
                else                     hold_d  = hold_q + 1'b1;
            end
            PLAY: begin
                if (level_lose) begin
                    lose_entry = 1'b1;
                end else if (level_win) begin
                    state_d = WIN;
                end
`ifdef LEVEL_TIMER_EN
                else if (tick && secs_q > 0) begin
                    secs_d = secs_q - 1;
                    if (secs_q == 1) lose_entry = 1'b1;
                end
`endif
                if (lose_entry) begin
                    state_d = LOSE;
                    lives_d = (lives_q != 4'd0) ? lives_q - 4'd1 : 4'd0;
                end
            end
            WIN: begin
                if (tick) begin
                    if (hold_q != HOLD_LAST) begin
                        hold_d = hold_q + 1'b1;
                    end else if (sel_q == LAST_LEVEL) begin
                        state_d = DONE;
                        won_d   = 1'b1;
                    end else begin
                        state_d = LOAD;
                        sel_d   = sel_q + 4'd1;
                    end
                end
            end
            LOSE: begin
                if (tick) begin
                    if (hold_q != HOLD_LAST) begin
                        hold_d = hold_q + 1'b1;
                    end else if (lives_q == 4'd0) begin
                        state_d = GAMEOVER;
                        lost_d  = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            DONE, GAMEOVER: begin
                if (jump_rise) begin
                    state_d = IDLE;
                    sel_d   = 4'd0;
                    lives_d = LIVES_INIT;
                    won_d   = 1'b0;
                    lost_d  = 1'b0;
                    secs_d  = SECS_INIT;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) hold_d = '0;
        if (state_d == LOAD)    secs_d = SECS_INIT;
        lrst_d = (state_d != LOAD);
    end

    // Divider restarts on every state entry and is held clear through LOAD.
    assign clear = (state_d != state_q) || (state_q == LOAD);

    second_ticker #(
        .CLOCK_HZ(CLOCK_HZ)
    ) u_ticker (
        .vga_clock(vga_clock),
        .reset    (reset),
        .clear    (clear),
        .tick     (tick)
    );

    always_ff @(posedge vga_clock) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= 4'd0;
            lives_q     <= LIVES_INIT;
            won_q       <= 1'b0;
            lost_q      <= 1'b0;
            secs_q      <= SECS_INIT;
            hold_q      <= '0;
            lrst_q      <= 1'b1;
            jump_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            lives_q     <= lives_d;
            won_q       <= won_d;
            lost_q      <= lost_d;
            secs_q      <= secs_d;
            hold_q      <= hold_d;
            lrst_q      <= lrst_d;
            jump_prev_q <= jump_button;
        end
    end

    assign level_sel   = sel_q;
    assign level_reset = lrst_q;
    assign seconds     = secs_q;
    assign state       = state_q;
    assign game_won    = won_q;
    assign game_lost   = lost_q;
    assign leds        = {lost_q, won_q, lives_q, sel_q};

endmodule

// File: tb/tb_level_sequencer.sv
// tb_level_sequencer: scoreboard bench for level_sequencer. Each scenario pushes the expected
// per-cycle snapshot {state, level_sel, level_reset, seconds[7:0], won, lost, leds} and then
// pops one entry per cycle, comparing against the DUT sampled on the falling edge.
module tb_level_sequencer;
    import game_pkg::*;

    localparam int unsigned CLOCK_HZ     = 10;
    localparam int unsigned NUM_LEVELS   = 3;
    localparam int unsigned TIME_LIMIT   = 3;
    localparam int unsigned LIVES        = 2;
    localparam int unsigned LOAD_CYCLES  = 4;
    localparam int unsigned HOLD_SECONDS = 1;

    logic       vga_clock;
    logic       reset;
    logic       jump_button;
    logic       level_win;
    logic       level_lose;
    logic [3:0] level_sel;
    logic       level_reset;
    int         seconds;
    logic [2:0] state;
    logic       game_won;
    logic       game_lost;
    logic [9:0] leds;

    logic [27:0] sb[$];
    logic [27:0] got, exp_v;
    int          checks = 0;
    int          passed = 0;
    int          exp_lives = 2;

    level_sequencer #(
        .CLOCK_HZ    (CLOCK_HZ),
        .NUM_LEVELS  (NUM_LEVELS),
        .TIME_LIMIT  (TIME_LIMIT),
        .LIVES       (LIVES),
        .LOAD_CYCLES (LOAD_CYCLES),
        .HOLD_SECONDS(HOLD_SECONDS)
    ) dut (
        .vga_clock  (vga_clock),
        .reset      (reset),
        .jump_button(jump_button),
        .level_win  (level_win),
        .level_lose (level_lose),
        .level_sel  (level_sel),
        .level_reset(level_reset),
        .seconds    (seconds),
        .state      (state),
        .game_won   (game_won),
        .game_lost  (game_lost),
        .leds       (leds)
    );

    initial begin
        vga_clock = 1'b0;
        forever #5 vga_clock = ~vga_clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    function automatic logic [27:0] mk(input game_state_t st, input int sel, input bit lr,
                                       input int secs, input bit won, input bit lost,
                                       input int lives);
        logic [9:0] l;
        l = {lost, won, 4'(lives), 4'(sel)};
        return {st, 4'(sel), lr, 8'(secs), won, lost, l};
    endfunction

    function automatic logic [27:0] snap();
        return {state, level_sel, level_reset, seconds[7:0], game_won, game_lost, leds};
    endfunction

    function automatic void push_n(input logic [27:0] v, input int n);
        repeat (n) sb.push_back(v);
    endfunction

    task automatic test_reset();
        reset = 1'b1; jump_button = 1'b0; level_win = 1'b0; level_lose = 1'b0;
        push_n(mk(IDLE, 0, 1, 3, 0, 0, 2), 3);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge vga_clock);
            got = snap(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) $display("FAIL reset[%0d]: got %h expected %h", i, got, exp_v);
            else passed++;
            if (i == 0) reset = 1'b0;
        end
    endtask

    task automatic test_start();
        jump_button = 1'b1;
        push_n(mk(LOAD, 1, 0, 3, 0, 0, exp_lives), 4);
        push_n(mk(PLAY, 1, 1, 3, 0, 0, exp_lives), 1);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge vga_clock);
            got = snap(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) $display("FAIL start[%0d]: got %h expected %h", i, got, exp_v);
            else passed++;
            if (i == 0) jump_button = 1'b0;
            if (i == 1) jump_button = 1'b1;  // press during LOAD must be ignored
            if (i == 2) jump_button = 1'b0;
        end
    endtask

`ifdef LEVEL_TIMER_EN
    task automatic test_timeout();
        exp_lives = exp_lives - 1;
        push_n(mk(PLAY, 1, 1, 3, 0, 0, 2), 9);
        push_n(mk(PLAY, 1, 1, 2, 0, 0, 2), 10);
        push_n(mk(PLAY, 1, 1, 1, 0, 0, 2), 10);
        push_n(mk(LOSE, 1, 1, 0, 0, 0, exp_lives), 10);
        push_n(mk(LOAD, 1, 0, 3, 0, 0, exp_lives), 4);
        push_n(mk(PLAY, 1, 1, 3, 0, 0, exp_lives), 1);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge vga_clock);
            got = snap(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) $display("FAIL timeout[%0d]: got %h expected %h", i, got, exp_v);
            else passed++;
            if (i == 31) jump_button = 1'b1;  // press during LOSE must be ignored
            if (i == 32) jump_button = 1'b0;
        end
    endtask
`else
    task automatic test_no_timer();
        push_n(mk(PLAY, 1, 1, 3, 0, 0, exp_lives), 100);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge vga_clock);
            got = snap(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) $display("FAIL no_timer[%0d]: got %h expected %h", i, got, exp_v);
            else passed++;
        end
    endtask
`endif

    task automatic test_priority();
        level_win = 1'b1; level_lose = 1'b1;
        exp_lives = exp_lives - 1;
        push_n(mk(LOSE, 1, 1, 3, 0, 0, exp_lives), 10);
        if (exp_lives > 0) begin
            push_n(mk(LOAD, 1, 0, 3, 0, 0, exp_lives), 4);
            push_n(mk(PLAY, 1, 1, 3, 0, 0, exp_lives), 1);
        end else begin
            push_n(mk(GAMEOVER, 1, 1, 3, 0, 1, 0), 1);
        end
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge vga_clock);
            got = snap(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) $display("FAIL priority[%0d]: got %h expected %h", i, got, exp_v);
            else passed++;
            if (i == 0) level_lose = 1'b0;
            if (i == 3) level_win = 1'b0;  // win held into LOSE must be ignored
        end
    endtask

    task automatic test_gameover();
        while (exp_lives > 0) begin
            level_lose = 1'b1;
            exp_lives = exp_lives - 1;
            push_n(mk(LOSE, 1, 1, 3, 0, 0, exp_lives), 10);
            if (exp_lives > 0) begin
                push_n(mk(LOAD, 1, 0, 3, 0, 0, exp_lives), 4);
                push_n(mk(PLAY, 1, 1, 3, 0, 0, exp_lives), 1);
            end else begin
                push_n(mk(GAMEOVER, 1, 1, 3, 0, 1, 0), 1);
            end
            for (int i = 0; sb.size() > 0; i++) begin
                @(negedge vga_clock);
                got = snap(); exp_v = sb.pop_front(); checks++;
                if (got !== exp_v) $display("FAIL gameover[%0d]: got %h expected %h", i, got, exp_v);
                else passed++;
                if (i == 0) level_lose = 1'b0;
            end
        end
        push_n(mk(GAMEOVER, 1, 1, 3, 0, 1, 0), 3);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge vga_clock);
            got = snap(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) $display("FAIL gameover_hold[%0d]: got %h expected %h", i, got, exp_v);
            else passed++;
        end
    endtask

    task automatic test_restart();
        jump_button = 1'b1;
        exp_lives = 2;
        push_n(mk(IDLE, 0, 1, 3, 0, 0, 2), 3);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge vga_clock);
            got = snap(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) $display("FAIL restart[%0d]: got %h expected %h", i, got, exp_v);
            else passed++;
            if (i == 0) jump_button = 1'b0;
        end
    endtask

    task automatic test_progression();
        jump_button = 1'b1;
        push_n(mk(LOAD, 1, 0, 3, 0, 0, 2), 4);   // i 0..3
        push_n(mk(PLAY, 1, 1, 3, 0, 0, 2), 1);   // i 4
        push_n(mk(WIN,  1, 1, 3, 0, 0, 2), 10);  // i 5..14
        push_n(mk(LOAD, 2, 0, 3, 0, 0, 2), 4);   // i 15..18
        push_n(mk(PLAY, 2, 1, 3, 0, 0, 2), 1);   // i 19
        push_n(mk(WIN,  2, 1, 3, 0, 0, 2), 10);  // i 20..29
        push_n(mk(DONE, 2, 1, 3, 1, 0, 2), 3);   // i 30..32
        push_n(mk(IDLE, 0, 1, 3, 0, 0, 2), 2);   // i 33..34
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge vga_clock);
            got = snap(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) $display("FAIL progression[%0d]: got %h expected %h", i, got, exp_v);
            else passed++;
            if (i == 0)  jump_button = 1'b0;
            if (i == 4)  level_win = 1'b1;
            if (i == 5)  level_win = 1'b0;
            if (i == 7)  jump_button = 1'b1;  // press during WIN must be ignored
            if (i == 8)  jump_button = 1'b0;
            if (i == 19) level_win = 1'b1;
            if (i == 20) level_win = 1'b0;
            if (i == 32) jump_button = 1'b1;
            if (i == 33) jump_button = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
`ifdef LEVEL_TIMER_EN
        int secs_late = 2;
`else
        int secs_late = 3;
`endif
        jump_button = 1'b1;
        push_n(mk(LOAD, 1, 0, 3, 0, 0, 2), 4);           // i 0..3
        push_n(mk(PLAY, 1, 1, 3, 0, 0, 2), 10);          // i 4..13
        push_n(mk(PLAY, 1, 1, secs_late, 0, 0, 2), 1);  // i 14
        push_n(mk(IDLE, 0, 1, 3, 0, 0, 2), 2);           // i 15..16
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge vga_clock);
            got = snap(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) $display("FAIL reset_mid[%0d]: got %h expected %h", i, got, exp_v);
            else passed++;
            if (i == 0)  jump_button = 1'b0;
            if (i == 14) reset = 1'b1;
            if (i == 15) reset = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_start();
`ifdef LEVEL_TIMER_EN
        test_timeout();
`else
        test_no_timer();
`endif
        test_priority();
        test_gameover();
        test_restart();
        test_progression();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/level_sequencer.md
# level_sequencer

Game-flow controller that sequences the level modules feeding the VGA renderer. Selects which level drives the background/sprite mux, resets each level on entry, and runs the per-level countdown shown as `seconds`. Consumes the selected level's `win`/`lose` flags and manages lives and the final won/lost outcome. Sits between the board I/O (switches, buttons, LEDs) and the level mux in the top level.

## Interface
- `CLOCK_HZ`, 25_000_000: `vga_clock` frequency; one-second tick period in cycles.
- `NUM_LEVELS`, 3: level count including index 0, the pre-level/attract screen; playable levels are 1..NUM_LEVELS-1.
- `TIME_LIMIT`, 60: seconds loaded at each level start.
- `LIVES`, 3: lives at game start; legal range 1..15.
- `LOAD_CYCLES`, 4: cycles `level_reset` is held low on level entry.
- `HOLD_SECONDS`, 2: seconds spent in WIN/LOSE before advancing.
- `vga_clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `jump_button`  in  1  start/continue; active-high, already debounced; rising edge acts.
- `level_win`  in  1  win flag from the selected level.
- `level_lose`  in  1  lose flag from the selected level.
- `level_sel`  out  4  level index for the mux.
- `level_reset`  out  1  active-low reset to the level modules.
- `seconds`  out  int  seconds remaining, for the renderer.
- `state`  out  3  current `game_state_t`.
- `game_won`  out  1  high in DONE.
- `game_lost`  out  1  high in GAMEOVER.
- `leds`  out  10  [3:0] `level_sel`, [7:4] lives, [8] `game_won`, [9] `game_lost`.

## Operation
- States: IDLE, LOAD, PLAY, WIN, LOSE, DONE, GAMEOVER.
- Reset values: state IDLE, `level_sel`=0, `level_reset`=1, `seconds`=TIME_LIMIT, lives=LIVES, `game_won`=`game_lost`=0, `leds`=lives<<4.
- IDLE: `level_sel`=0. A `jump_button` rising edge sets `level_sel`=1 and goes to LOAD.
- LOAD: `level_reset`=0 for exactly LOAD_CYCLES cycles. `seconds`=TIME_LIMIT and the tick divider is cleared. Then PLAY.
- PLAY: `level_reset`=1. Each tick decrements `seconds`. Exits, highest priority first:
  - `level_lose` -> LOSE
  - `level_win` -> WIN
  - tick while `seconds`==1 -> `seconds`=0, then LOSE
- `seconds` never wraps below 0. Win/lose flags are ignored outside PLAY.
- LOSE: lives decrement on entry. After HOLD_SECONDS ticks: lives==0 -> GAMEOVER, else LOAD with the same `level_sel`.
- WIN: after HOLD_SECONDS ticks: `level_sel`==NUM_LEVELS-1 -> DONE, else `level_sel`+1 -> LOAD.
- WIN and LOSE freeze `seconds`.
- DONE/GAMEOVER: `game_won`/`game_lost` held high. A `jump_button` rising edge returns to IDLE and restores all reset values except `reset` itself.
- A button edge during LOAD, PLAY, WIN or LOSE is ignored.
- Hold counter and tick divider clear on every state entry.

## Timing
- All outputs registered; each changes on the edge after the causing condition is sampled.
- Button edge detect uses a registered previous value. The press is seen in cycle N, and state changes at edge N+1.
- `level_reset` falls on the edge that enters LOAD and rises LOAD_CYCLES edges later, coincident with entry to PLAY.
- Tick: single-cycle pulse every CLOCK_HZ cycles after a clear. The first decrement comes CLOCK_HZ cycles into PLAY.
- Reset asserted mid-game: all registers take reset values at the next edge, regardless of state.

## Configuration
- `LEVEL_TIMER_EN` defined: countdown and timeout-to-LOSE as above.
- `LEVEL_TIMER_EN` undefined: `seconds` held at TIME_LIMIT and no timeout. The tick divider is still built for WIN/LOSE hold timing.

## Structure
- `game_pkg`: `game_state_t` enum (7 states, 3 bits); tile codes BDR/SKY/BLK/GND/TKN/CK1/CK2 as shared constants.
- Sub-module `second_ticker`:
  - inputs `vga_clock`, `reset`, `clear`; output `tick`
  - counter width $clog2(CLOCK_HZ)
  - instanced once.

## Test plan
Sim parameters: CLOCK_HZ=10, TIME_LIMIT=3, LIVES=2, NUM_LEVELS=3, HOLD_SECONDS=1.
- Start: reset, pulse `jump_button` -> LOAD with `level_sel`=1, `level_reset` low for 4 cycles, then PLAY with `seconds`=3.
- Timeout: no flags -> `seconds` 3,2,1,0 at 10-cycle spacing, then LOSE with lives=1, then LOAD of level 1 after 10 cycles.
- Priority: `level_win` and `level_lose` both high in the same PLAY cycle -> LOSE; a second loss -> GAMEOVER with `game_lost`=1, `leds[9]`=1.
- Progression: `level_win` in level 1 -> WIN, then level 2; `level_win` again -> DONE, `game_won`=1; button -> IDLE, lives=2.
- Reset mid-PLAY at `seconds`=2 -> next edge IDLE, `seconds`=3, `level_sel`=0, `level_reset`=1.
- Build without `LEVEL_TIMER_EN` -> `seconds` stays 3 for 100 cycles of PLAY; no LOSE.
